instr_mem_loadable: RTL and testbench
=====================================

# instr_mem_loadable

Parametrised, loadable instruction memory that supplies instruction words to the fetch stage of the single-cycle datapath. It adds three things over a fixed ROM: a registered fetch port with a valid handshake, a streaming load port for reprogramming at run time, and an automatic clear-to-NOP sweep after reset. It sits between the PC/fetch logic and the decoder, and is loaded by the test harness or a boot controller.

## Interface
Parameters:
- DATA_WIDTH, 16: instruction word width.
- ADDR_WIDTH, 6: fetch/load address width.
- DEPTH, 16: number of stored words; must satisfy DEPTH <= 2^ADDR_WIDTH.
- NOP_WORD, 16'h3000: fill and substitute word (the ISA NOOP).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- fetch_req, input, 1: fetch request.
- fetch_addr, input, ADDR_WIDTH: word address to fetch.
- fetch_ready, output, 1: a fetch is accepted this cycle.
- instr_valid, output, 1: instruction holds fetched data.
- instruction, output, DATA_WIDTH: fetched word.
- addr_err, output, 1: the fetch being presented had address >= DEPTH.
- load_start, input, 1: request entry to load mode.
- load_valid, input, 1: load_data is valid.
- load_data, input, DATA_WIDTH: word to write.
- load_last, input, 1: final word of the load burst.
- load_ready, output, 1: a load word is accepted this cycle.
- load_done, output, 1: one-cycle pulse when a load completes.
- parity_err, output, 1: stored-word parity mismatch (see Configuration).

## Operation
- The FSM has three states: CLEAR, RUN and LOAD.
- CLEAR is entered on reset.
  - A pointer walks 0..DEPTH-1, writing NOP_WORD to one word per cycle.
  - After writing word DEPTH-1, the FSM goes to RUN.
  - fetch_ready = 0 and load_ready = 0 throughout CLEAR.
- RUN:
  - fetch_ready = 1.
  - An accepted fetch is fetch_req & fetch_ready.
  - If fetch_addr < DEPTH, the stored word is returned.
  - Otherwise NOP_WORD is returned and addr_err = 1, aligned with instr_valid.
  - load_start moves the FSM to LOAD on the next edge and clears the write pointer to 0.
- LOAD:
  - load_ready = 1 and fetch_ready = 0.
  - Each load_valid & load_ready writes load_data at the pointer, then the pointer increments.
  - The load exits to RUN after the word accepted with load_last = 1, or after the write at DEPTH-1, whichever comes first.
  - On exit, load_done pulses for one cycle.
  - Words that were not written keep their previous contents.
- Simultaneous load_start and fetch_req in RUN: the fetch is accepted and completes normally, and LOAD is entered on the next cycle.
- load_start in CLEAR or LOAD is ignored.
- The pointer width is ADDR_WIDTH; arithmetic never wraps past DEPTH-1 because the exit condition comes first.

## Timing
- Fetch latency is 1 cycle: a fetch accepted at edge N gives instruction, instr_valid = 1 and addr_err after edge N+1.
- instr_valid = 0 in any cycle following a non-accepted fetch.
- instruction holds its last value when instr_valid = 0.
- A load write at edge N is visible to a fetch accepted at edge N+1 or later.
- CLEAR lasts exactly DEPTH cycles after rst deasserts; fetch_ready rises in cycle DEPTH+1.
- Reset values: instruction = 0, instr_valid = 0, addr_err = 0, fetch_ready = 0, load_ready = 0, load_done = 0, parity_err = 0.
- Reset asserted mid-LOAD or mid-fetch:
  - All outputs go to their reset values immediately.
  - The in-flight fetch is discarded.
  - CLEAR restarts from word 0 once rst deasserts.

## Configuration
- INSTR_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, computed on every write (including CLEAR).
  - On fetch, a parity mismatch sets parity_err = 1 aligned with instr_valid, and instruction is forced to NOP_WORD.
- INSTR_MEM_PARITY_EN undefined:
  - No parity storage.
  - parity_err is tied to 0.

## Test plan
- Reset, then fetch addresses 0..15 -> fetch_ready rises 16 cycles after rst drops; every fetch returns 16'h3000 with instr_valid one cycle later.
- load_start, then 8 words 16'h2108, 16'hE202, ... with load_last on word 8 -> load_done pulses once; fetches 0..7 return the loaded words; fetches 8..15 return 16'h3000.
- Fetch addr 6'd20 in RUN -> instruction = 16'h3000 and addr_err = 1 for one cycle.
- Load 16 words without load_last -> automatic exit after word 15 with load_done; a load_valid presented afterwards is ignored (load_ready = 0).
- load_start together with fetch_req at addr 3 -> the fetch returns the pre-load word; LOAD begins the next cycle; fetch_ready = 0 during the load.
- rst pulsed after 4 load words -> outputs go to 0 immediately; fetches after CLEAR return 16'h3000.
- With INSTR_MEM_PARITY_EN, force-flip one stored bit at addr 2 -> fetching addr 2 gives parity_err = 1 and instruction = 16'h3000.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// instr_mem_loadable_if
// Bundles the fetch and load handshakes of the loadable instruction memory.
//   master : fetch/PC logic plus load source (harness or boot controller)
//   slave  : the instruction memory itself
// Fetch : fetch_req, fetch_addr -> fetch_ready, instr_valid, instruction,
//         addr_err, parity_err
// Load  : load_start, load_valid, load_data, load_last -> load_ready, load_done
interface instr_mem_loadable_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  addr_err;
  logic                  load_start;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic                  parity_err;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_ready, instr_valid, instruction, addr_err,
           load_ready, load_done, parity_err
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_ready, instr_valid, instruction, addr_err,
           load_ready, load_done, parity_err
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
// Loadable instruction memory feeding the fetch stage. After reset it sweeps
// every word to NOP_WORD, then serves registered fetches (1-cycle latency) and
// accepts streaming load bursts that rewrite words from address 0 upward.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : instr_mem_loadable_if.slave (fetch and load handshakes)
// Optional build macro INSTR_MEM_PARITY_EN adds an even-parity bit per word;
// a mismatched fetch reports parity_err and returns NOP_WORD.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | writing NOP_WORD to word ptr_q each cycle, no handshakes
// S_RUN   | fetches accepted; load_start moves to S_LOAD
// S_LOAD  | load words written at ptr_q; exits on load_last or last word
module instr_mem_loadable #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 16'h3000
) (
  input logic                 clk,
  input logic                 rst,
  instr_mem_loadable_if.slave bus
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  load_done_q, load_done_d;
  logic                  instr_valid_q;
  logic                  addr_err_q;
  logic                  parity_err_q;
  logic [DATA_WIDTH-1:0] instruction_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_par_bad;
  logic                  addr_in_range;
  logic                  fetch_acc;

  assign bus.fetch_ready = (state_q == S_RUN);
  assign bus.load_ready  = (state_q == S_LOAD);
  assign fetch_acc       = bus.fetch_req & bus.fetch_ready;

  assign addr_in_range = ({1'b0, bus.fetch_addr} < DEPTH_EXT);
  assign rd_idx        = bus.fetch_addr[IDX_W-1:0];
  assign wr_idx        = ptr_q[IDX_W-1:0];
  assign rd_data       = mem_q[rd_idx];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_en       = 1'b0;
    wr_data     = NOP_WORD;
    load_done_d = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = S_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      S_RUN: begin
        // A fetch presented alongside load_start still completes this cycle.
        if (bus.load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.load_valid) begin
          wr_en   = 1'b1;
          wr_data = bus.load_data;
          // Exit at the last word even without load_last so ptr never wraps.
          if (bus.load_last || (ptr_q == LAST_PTR)) begin
            state_d     = S_RUN;
            ptr_d       = '0;
            load_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_q[wr_idx] <= ^wr_data;
  end

  assign rd_par_bad = (^rd_data) != par_q[rd_idx];
`else
  assign rd_par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      ptr_q         <= '0;
      load_done_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      instruction_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_done_q   <= load_done_d;
      instr_valid_q <= fetch_acc;
      addr_err_q    <= fetch_acc & ~addr_in_range;
      parity_err_q  <= fetch_acc & addr_in_range & rd_par_bad;
      // instruction holds its last value when no fetch is accepted.
      if (fetch_acc) begin
        instruction_q <= (!addr_in_range || rd_par_bad) ? NOP_WORD : rd_data;
      end
    end
  end

  assign bus.instr_valid = instr_valid_q;
  assign bus.instruction = instruction_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.load_done   = load_done_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  localparam int          DW    = 16;
  localparam int          AW    = 6;
  localparam int          DEPTH = 16;
  localparam logic [15:0] NOP   = 16'h3000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] model [DEPTH];

  instr_mem_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem_loadable #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   exp_instr;
    logic          exp_err;
  } fetch_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {10'd0, bus.instruction, bus.instr_valid, bus.addr_err, bus.fetch_ready,
             bus.load_ready, bus.load_done, bus.parity_err}, 32'd0);
  endtask

  // Counts edges from rst release until fetch_ready rises; CLEAR must take DEPTH.
  task automatic wait_run();
    int cnt;
    cnt = 0;
    while (!bus.fetch_ready && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("clear_cycles", cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
  endtask

  // One accepted fetch; the result is visible right after the next edge.
  task automatic fetch_chk(input logic [AW-1:0] a);
    logic [15:0] exp;
    exp = (a < DEPTH) ? model[a] : NOP;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    tick();
    bus.fetch_req = 1'b0;
    chk("fetch_valid", bus.instr_valid, 1'b1);
    chk("fetch_instr", bus.instruction, exp);
    chk("fetch_addr_err", bus.addr_err, (a >= DEPTH));
    chk("fetch_parity_err", bus.parity_err, 1'b0);
  endtask

  task automatic idle_chk(input logic [15:0] held);
    bus.fetch_req = 1'b0;
    tick();
    chk("idle_valid", bus.instr_valid, 1'b0);
    chk("idle_addr_err", bus.addr_err, 1'b0);
    chk("idle_instr_hold", bus.instruction, held);
  endtask

  // Streams n words; last_at marks the load_last word (-1 for none).
  // The model exits at load_last or after the word at DEPTH-1.
  task automatic do_load(input logic [15:0] dat [DEPTH], input int n, input int last_at,
                         input bit gaps, input bit already_started);
    int ptr;
    bit done;
    if (!already_started) begin
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
    end
    chk("load_entry_ready", bus.load_ready, 1'b1);
    chk("load_entry_fetch_ready", bus.fetch_ready, 1'b0);
    ptr  = 0;
    done = 1'b0;
    for (int k = 0; k < n && !done; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 2) != 0) break;
          bus.load_valid = 1'b0;
          tick();
          chk("load_gap_done", bus.load_done, 1'b0);
        end
      end
      bus.load_valid = 1'b1;
      bus.load_data  = dat[k];
      bus.load_last  = (k == last_at);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      model[ptr] = dat[k];
      done = (k == last_at) || (ptr == DEPTH - 1);
      ptr++;
      chk("load_done", bus.load_done, done);
      chk("load_ready", bus.load_ready, !done);
      chk("no_fetch_in_load", bus.instr_valid, 1'b0);
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.fetch_req  = 1'b0;
    tick();
    chk("load_done_one_cycle", bus.load_done, 1'b0);
  endtask

  initial begin
    fetch_vec_t  vecs [18];
    logic [15:0] first_words [DEPTH];
    logic [15:0] dat [DEPTH];
    logic [15:0] last_instr;
    int          n;
    int          last_at;

    first_words = '{16'h2108, 16'hE202, 16'h1234, 16'h4567, 16'h89AB, 16'hCDEF,
                    16'h0F0F, 16'hF0F0, 16'h0, 16'h0, 16'h0, 16'h0,
                    16'h0, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++)  vecs[i] = '{AW'(i), first_words[i], 1'b0};
    for (int i = 8; i < 16; i++) vecs[i] = '{AW'(i), 16'h3000, 1'b0};
    vecs[16] = '{6'd20, 16'h3000, 1'b1};
    vecs[17] = '{6'd63, 16'h3000, 1'b1};

    total = 0;
    bad   = 0;
    rst            = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;

    repeat (3) tick();
    chk_reset_outputs("reset_outputs");
    rst = 1'b0;
    wait_run();

    for (int a = 0; a < DEPTH; a++) fetch_chk(AW'(a));
    idle_chk(NOP);

    // 8-word burst with load_last on the 8th word, then table-driven fetches.
    do_load(first_words, 8, 7, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = vecs[i].addr;
      tick();
      chk("vec_valid", bus.instr_valid, 1'b1);
      chk("vec_instr", bus.instruction, vecs[i].exp_instr);
      chk("vec_addr_err", bus.addr_err, vecs[i].exp_err);
    end
    idle_chk(NOP);

    fetch_chk(6'd20);
    idle_chk(NOP);

    // Full 16-word burst without load_last; trailing load_valid is ignored.
    for (int i = 0; i < DEPTH; i++) dat[i] = 16'($urandom);
    do_load(dat, DEPTH, -1, 1'b0, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'hDEAD;
    repeat (2) begin
      tick();
      chk("post_load_ready", bus.load_ready, 1'b0);
      chk("post_load_done", bus.load_done, 1'b0);
    end
    bus.load_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) fetch_chk(AW'(a));

    // load_start together with a fetch: the fetch sees pre-load contents.
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd3;
    tick();
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    chk("simul_valid", bus.instr_valid, 1'b1);
    chk("simul_instr_preload", bus.instruction, model[3]);
    for (int i = 0; i < DEPTH; i++) dat[i] = 16'($urandom);
    do_load(dat, 5, 4, 1'b1, 1'b1);
    for (int a = 0; a < DEPTH; a++) fetch_chk(AW'(a));

    // Randomized mix of fetch bursts and load bursts against the model.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 8)) begin
          if ($urandom_range(0, 3) == 0) begin
            last_instr = bus.instruction;
            idle_chk(last_instr);
          end else begin
            fetch_chk(AW'($urandom_range(0, 63)));
          end
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) dat[i] = 16'($urandom);
        n = $urandom_range(1, DEPTH);
        if (n < DEPTH) last_at = $urandom_range(0, n - 1);
        else last_at = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, DEPTH - 1);
        do_load(dat, n, last_at, 1'b1, 1'b0);
      end
    end

    // Reset in the middle of a load burst, with a fetch request pending.
    for (int i = 0; i < DEPTH; i++) dat[i] = 16'($urandom);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.load_data = dat[k];
      tick();
    end
    bus.fetch_req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_load_reset_outputs");
    bus.load_valid = 1'b0;
    bus.fetch_req  = 1'b0;
    tick();
    chk_reset_outputs("mid_load_reset_hold");
    rst = 1'b0;
    wait_run();
    for (int a = 0; a < DEPTH; a++) fetch_chk(AW'(a));

    // Reset while a fetch result is in flight: it must be discarded.
    fetch_chk(6'd5);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd7;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_fetch_reset_outputs");
    bus.fetch_req = 1'b0;
    tick();
    chk_reset_outputs("mid_fetch_reset_hold");
    rst = 1'b0;
    wait_run();
    fetch_chk(6'd7);

`ifdef INSTR_MEM_PARITY_EN
    dut.mem_q[2] = dut.mem_q[2] ^ 16'h0001;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 6'd2;
    tick();
    bus.fetch_req = 1'b0;
    chk("parity_err_flag", bus.parity_err, 1'b1);
    chk("parity_err_instr", bus.instruction, NOP);
    chk("parity_err_valid", bus.instr_valid, 1'b1);
    tick();
    chk("parity_err_clear", bus.parity_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
